// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the RISC-V datapath and a word-addressed,
// variable-latency data memory with a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_req, i_we, i_funct3   datapath request, store flag, access size/sign
//   i_addr, i_wdata         byte address and store data
//   o_rdata                 extended load result (holds between loads)
//   o_done, o_err           one-cycle completion pulse, error flag qualified by done
//   o_stall                 combinational: i_req & ~o_done
//   o_mem_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata  memory request
//   i_mem_ready, i_mem_rdata                                  memory response
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_stall,
  output logic        o_mem_valid,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_off;
  logic [2:0]         r_funct3;
  logic [31:0]        r_rdata;
  logic               r_done;
  logic               r_err;
  logic               r_mem_valid;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [3:0]         r_mem_be;
  logic [31:0]        r_mem_wdata;

  logic [1:0]         w_off;
  logic               w_illegal;
  logic               w_misaligned;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;

  assign w_off = i_addr[1:0];

  // Request decode: legality, alignment, byte enables and lane-replicated data.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = i_wdata;
    case (i_funct3[1:0])
      2'd0: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'd1: begin
        w_be         = 4'b0011 << w_off;
        w_wdata      = {2{i_wdata[15:0]}};
        w_misaligned = w_off[0];
      end
      default: begin
        w_be         = 4'b1111;
        w_wdata      = i_wdata;
        w_misaligned = |w_off;
      end
    endcase
    if (i_we) begin
      // Stores only know sb/sh/sw.
      w_illegal = (i_funct3 > 3'd2);
    end else begin
      // Loads: 3, 6 and 7 are unused encodings.
      w_illegal = (i_funct3 == 3'd3) || (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
    end
  end

  // Load extraction from the returned word using the offset captured in IDLE.
  always_comb begin
    w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
    w_half = i_mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = i_mem_rdata;
    endcase
  end

  // Access FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_off       <= 2'd0;
      r_funct3    <= 3'd0;
      r_rdata     <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            if (w_illegal || w_misaligned) begin
              // Rejected before touching the bus.
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_we    <= i_we;
              r_mem_addr  <= {i_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_off       <= w_off;
              r_funct3    <= i_funct3;
              r_cnt       <= '0;
              r_state     <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            if (!r_mem_we) begin
              r_rdata <= w_load;
            end
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            // Abort: memory never answered within the window.
            r_mem_valid <= 1'b0;
            if (!r_mem_we) begin
              r_rdata <= 32'd0;
            end
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rdata     = r_rdata;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_stall     = i_req & ~r_done;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit between the RISC-V datapath and a data memory that is word-addressed and has variable latency. It accepts one load or store per request and drives byte-enabled word accesses on a valid/ready memory port. On loads it extracts the addressed byte or halfword and sign- or zero-extends it. It stalls the core until the access completes and reports misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, number of cycles mem_valid may stay high without mem_ready before the access is aborted (range 1..65535).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req  in  1  datapath access request; held high with stable inputs until done
we  in  1  1 = store, 0 = load
funct3  in  3  instruction funct3 (load: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; store: 0 sb, 1 sh, 2 sw)
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
rdata  out  32  extended load result (registered)
done  out  1  one-cycle completion pulse
err  out  1  qualified by done: access misaligned, illegal or timed out
stall  out  1  req & ~done (combinational), freezes the PC
mem_valid  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  memory accepts or returns data
mem_rdata  in  32  memory read word, valid when mem_valid & mem_ready & ~mem_we

Behaviour:
- Reset state (rst low, asynchronous): FSM=IDLE, rdata=0, done=0, err=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- FSM states: IDLE, BUS, RESP.
- IDLE with req=1:
  - If funct3 is illegal (load 3/6/7, store >2) or the address is misaligned (h-type with addr[0]=1; w-type with addr[1:0]!=0), go to RESP with err=1. mem_valid never asserts and rdata is not updated.
  - Otherwise, register mem_addr, mem_we, mem_be and mem_wdata, clear the counter, and go to BUS.
- BUS:
  - mem_valid=1. All mem_* outputs stay stable until mem_ready.
  - Handshake on mem_valid & mem_ready. A load captures the extracted value into rdata. Go to RESP with err=0.
  - Each cycle without mem_ready increments the counter. When the counter reaches TIMEOUT_CYCLES-1 with no mem_ready, drop mem_valid, set rdata=0, and go to RESP with err=1.
- RESP: done=1 for exactly one cycle, then IDLE. A req seen in the following IDLE cycle is a new access. Stores never modify rdata.
- Latency: at least 3 cycles from req to done (IDLE, BUS, RESP) when mem_ready is already high. Each wait cycle adds one. Error paths take 2 cycles.
- Byte enables, with off=addr[1:0]:
  - sb: 4'b0001<<off
  - sh: 4'b0011<<off
  - sw: 4'b1111
- mem_wdata:
  - sb: {4{wdata[7:0]}}
  - sh: {2{wdata[15:0]}}
  - sw: wdata
- Load extraction:
  - byte = mem_rdata[8*off +: 8]
  - half = mem_rdata[16*off[1] +: 16]
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word unchanged.
- Reset asserted mid-access: all outputs clear immediately and the access is dropped. The memory side must tolerate the abandoned request. After release, a held req is served as a new access.
- rdata holds its last value between loads.

Test Plan:
1. lh addr=0x8, mem_rdata=0xdeadbeef, mem_ready=1 -> mem_addr=0x8, mem_be=0011, mem_valid for 1 cycle; done on the 3rd cycle after req; rdata=0xffffbeef, err=0.
2. Word 0xdeadbeef at address 0x8:
   - lhu 0xA -> 0x0000dead
   - lb 0xB -> 0xffffffde
   - lbu 0x9 -> 0x000000be
   - lw 0x8 -> 0xdeadbeef
3. sb addr=0x7, wdata=0x123456aa, mem_ready low for 3 cycles -> mem_addr=0x4, mem_be=1000, mem_wdata=0xaaaaaaaa, all stable while waiting; done 1 cycle after the handshake; rdata unchanged; stall high until done.
4. lw addr=0x6, and separately load funct3=3 -> mem_valid stays 0; done with err=1 in the 2nd cycle.
5. TIMEOUT_CYCLES=8, mem_ready held 0 -> mem_valid high exactly 8 cycles, then done with err=1 and rdata=0.
6. rst low while in BUS -> mem_valid=0 and done=0 within the same cycle; after rst goes high with req still high, the access restarts and completes normally.
